// File: rtl/xadc_sample_sequencer_pkg.sv
// Shared constants and types for the XADC sample sequencer.
// Holds the DRP status addresses of the two aux channels, the sequencer
// FSM state type and divider presets for the supported sample rates.
package xadc_sample_sequencer_pkg;

  // DRP status register addresses of the aux inputs
  localparam logic [6:0] ADDR_VT = 7'h16;  // VAUX6, voltage
  localparam logic [6:0] ADDR_CT = 7'h17;  // VAUX7, current

  // Divider presets at a 100 MHz system clock (non-integer ratios truncate)
  localparam int unsigned CLK_HZ            = 100_000_000;
  localparam int unsigned SAMPLE_DIV_512HZ  = CLK_HZ / 512;   // 195312
  localparam int unsigned SAMPLE_DIV_1280HZ = CLK_HZ / 1280;  // 78125
  localparam int unsigned SAMPLE_DIV_1024HZ = CLK_HZ / 1024;  // 97656

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/xadc_sample_sequencer_ram.sv
// sample_ring_ram: simple dual-port RAM for the voltage ring buffer.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (read register only)
//   wr_en_i    - write strobe
//   wr_addr_i  - write index
//   wr_data_i  - write data
//   rd_addr_i  - read index
//   rd_data_o  - registered read data, one cycle after rd_addr_i
// A same-address read/write in one cycle returns the previous contents.
module sample_ring_ram #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port; array contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/xadc_sample_sequencer.sv
// xadc_sample_sequencer: fixed-rate XADC DRP sampler feeding the FFT engines.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   sel_ct                 - channel select (0 voltage, 1 current), taken at tick
//   clr_flags              - clears overrun / timeout_err (set has priority)
//   drp_daddr, drp_den     - DRP read request towards xadc_wiz
//   drp_drdy, drp_do       - DRP read response
//   vt_start, vt_sample    - voltage sample strobe and held value
//   ct_start, ct_sample    - current sample strobe and held value
//   rd_addr, rd_data       - ring-buffer readout (1-cycle latency)
//   wr_ptr                 - next ring-buffer write index
//   overrun, timeout_err   - sticky error flags
module xadc_sample_sequencer
  import xadc_sample_sequencer_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = SAMPLE_DIV_1280HZ,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DRP_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel_ct,
  input  logic                     clr_flags,
  output logic [6:0]               drp_daddr,
  output logic                     drp_den,
  input  logic                     drp_drdy,
  input  logic [DATA_W-1:0]        drp_do,
  output logic                     vt_start,
  output logic [DATA_W-1:0]        vt_sample,
  output logic                     ct_start,
  output logic [DATA_W-1:0]        ct_sample,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TO_W  = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRP_TIMEOUT - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_c;
  seq_state_e        state_q;
  logic              ch_q;
  logic [TO_W-1:0]   wait_cnt_q;
  logic [6:0]        daddr_q;
  logic              den_q, vt_start_q, ct_start_q;
  logic [DATA_W-1:0] vt_sample_q, ct_sample_q;
  logic [AW-1:0]     wr_ptr_q;
  logic              overrun_q, timeout_q;
  logic              to_hit_c, ram_we_c;

  // Free-running sample divider, never stalled by the FSM
  assign tick_c = (div_q == DIV_LAST);
  assign div_d  = tick_c ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign to_hit_c = (state_q == WAIT) && !drp_drdy && (wait_cnt_q == TO_LAST);

  // Read sequencer; strobes are registered so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= 1'b0;
      wait_cnt_q  <= '0;
      daddr_q     <= ADDR_VT;
      den_q       <= 1'b0;
      vt_start_q  <= 1'b0;
      ct_start_q  <= 1'b0;
      vt_sample_q <= '0;
      ct_sample_q <= '0;
      wr_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      den_q      <= 1'b0;
      vt_start_q <= 1'b0;
      ct_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick_c) begin
            ch_q    <= sel_ct;
            daddr_q <= sel_ct ? ADDR_CT : ADDR_VT;
            den_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (drp_drdy) begin
            if (ch_q) begin
              ct_sample_q <= drp_do;
              ct_start_q  <= 1'b1;
            end else begin
              vt_sample_q <= drp_do;
              vt_start_q  <= 1'b1;
            end
            state_q <= DONE;
          end else if (to_hit_c) begin
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        DONE: begin
          // Pointer wraps naturally because DEPTH is a power of two
          if (!ch_q) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Sticky flags: a set event in the same cycle beats the clear
      if (tick_c && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clr_flags) begin
        overrun_q <= 1'b0;
      end
      if (to_hit_c) begin
        timeout_q <= 1'b1;
      end else if (clr_flags) begin
        timeout_q <= 1'b0;
      end
    end
  end

  // Only voltage samples are buffered, written during the start-pulse cycle
  assign ram_we_c = (state_q == DONE) && !ch_q && !rst;

  sample_ring_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (ram_we_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (vt_sample_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign drp_daddr   = daddr_q;
  assign drp_den     = den_q;
  assign vt_start    = vt_start_q;
  assign vt_sample   = vt_sample_q;
  assign ct_start    = ct_start_q;
  assign ct_sample   = ct_sample_q;
  assign wr_ptr      = wr_ptr_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_xadc_sample_sequencer.sv
// Bench for xadc_sample_sequencer. Instance A (DRP_TIMEOUT=4) covers reads,
// ring wrap, timeout and reset mid-read; instance B (DRP_TIMEOUT=16) covers overrun.
// Start pulses are checked against per-instance queues of expected samples.
module tb_xadc_sample_sequencer;

  localparam int unsigned DIV   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 2;

  typedef struct {
    logic          ch;
    logic [DW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic a_rst, a_sel, a_clr, a_drdy, a_den, a_vt_start, a_ct_start, a_ovr, a_to;
  logic [6:0] a_daddr;
  logic [DW-1:0] a_do, a_vt_sample, a_ct_sample, a_rd_data;
  logic [AW-1:0] a_rd_addr, a_wr_ptr;
  // Instance B signals
  logic b_rst, b_sel, b_clr, b_drdy, b_den, b_vt_start, b_ct_start, b_ovr, b_to;
  logic [6:0] b_daddr;
  logic [DW-1:0] b_do, b_vt_sample, b_ct_sample, b_rd_data;
  logic [AW-1:0] b_rd_addr, b_wr_ptr;

  ev_t q_a[$];
  ev_t q_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  xadc_sample_sequencer #(
    .SAMPLE_DIV(DIV), .DEPTH(DEPTH), .DATA_W(DW), .DRP_TIMEOUT(4)
  ) u_dut_a (
    .clk(clk), .rst(a_rst), .sel_ct(a_sel), .clr_flags(a_clr),
    .drp_daddr(a_daddr), .drp_den(a_den), .drp_drdy(a_drdy), .drp_do(a_do),
    .vt_start(a_vt_start), .vt_sample(a_vt_sample),
    .ct_start(a_ct_start), .ct_sample(a_ct_sample),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .wr_ptr(a_wr_ptr),
    .overrun(a_ovr), .timeout_err(a_to)
  );

  xadc_sample_sequencer #(
    .SAMPLE_DIV(DIV), .DEPTH(DEPTH), .DATA_W(DW), .DRP_TIMEOUT(16)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .sel_ct(b_sel), .clr_flags(b_clr),
    .drp_daddr(b_daddr), .drp_den(b_den), .drp_drdy(b_drdy), .drp_do(b_do),
    .vt_start(b_vt_start), .vt_sample(b_vt_sample),
    .ct_start(b_ct_start), .ct_sample(b_ct_sample),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_ptr(b_wr_ptr),
    .overrun(b_ovr), .timeout_err(b_to)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the next den on instance A or B; n = posedges waited
  task automatic wait_den(input bit use_b, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(use_b ? b_den : a_den) && n < 40);
    if (!(use_b ? b_den : a_den)) begin
      n_tests++;
      n_fail++;
      $display("FAIL den_wait_%s: no drp_den within 40 cycles", use_b ? "B" : "A");
    end
  endtask

  // Called in the den cycle: assert drdy with data 'delay' cycles later on instance A
  task automatic finish_a(input logic [DW-1:0] data, input int delay);
    repeat (delay) @(posedge clk);
    #1;
    a_drdy = 1'b1;
    a_do   = data;
    @(posedge clk); #1;
    a_drdy = 1'b0;
    a_do   = '0;
  endtask

  // Monitors: every start pulse must match the oldest expected sample
  always @(negedge clk) begin : mon_a
    ev_t e;
    if (a_vt_start || a_ct_start) begin
      if (q_a.size() == 0) begin
        check("A_unexpected_start", 32'({a_vt_start, a_ct_start}), 32'd0);
      end else begin
        e = q_a.pop_front();
        check("A_start_kind", 32'({a_vt_start, a_ct_start}), e.ch ? 32'd1 : 32'd2);
        check("A_sample", 32'(e.ch ? a_ct_sample : a_vt_sample), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    ev_t e;
    if (b_vt_start || b_ct_start) begin
      if (q_b.size() == 0) begin
        check("B_unexpected_start", 32'({b_vt_start, b_ct_start}), 32'd0);
      end else begin
        e = q_b.pop_front();
        check("B_start_kind", 32'({b_vt_start, b_ct_start}), e.ch ? 32'd1 : 32'd2);
        check("B_sample", 32'(e.ch ? b_ct_sample : b_vt_sample), 32'(e.data));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int den_cnt;
    logic [DW-1:0] wrap_exp [DEPTH];
    wrap_exp[0] = 16'd5; wrap_exp[1] = 16'd2; wrap_exp[2] = 16'd3; wrap_exp[3] = 16'd4;

    a_rst = 1'b1; a_sel = 1'b0; a_clr = 1'b0; a_drdy = 1'b0; a_do = '0; a_rd_addr = '0;
    b_rst = 1'b1; b_sel = 1'b0; b_clr = 1'b0; b_drdy = 1'b0; b_do = '0; b_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_den", 32'(a_den), 32'd0);
    check("rst_daddr", 32'(a_daddr), 32'h16);
    check("rst_starts", 32'({a_vt_start, a_ct_start}), 32'd0);
    check("rst_vt_sample", 32'(a_vt_sample), 32'd0);
    check("rst_ct_sample", 32'(a_ct_sample), 32'd0);
    check("rst_wr_ptr", 32'(a_wr_ptr), 32'd0);
    check("rst_flags", 32'({a_ovr, a_to}), 32'd0);
    check("rst_rd_data", 32'(a_rd_data), 32'd0);

    // Basic voltage read
    a_rst = 1'b0;
    q_a.push_back('{ch: 1'b0, data: 16'h1234});
    wait_den(1'b0, n);
    check("basic_den_cycle", 32'(n), 32'd8);
    check("basic_daddr", 32'(a_daddr), 32'h16);
    finish_a(16'h1234, 3);
    a_sel = 1'b1;
    a_rd_addr = '0;
    @(posedge clk); #1;
    check("basic_wr_ptr", 32'(a_wr_ptr), 32'd1);
    @(posedge clk); #1;
    check("basic_buf0", 32'(a_rd_data), 32'h1234);

    // Current read
    q_a.push_back('{ch: 1'b1, data: 16'hABCD});
    wait_den(1'b0, n);
    check("cur_daddr", 32'(a_daddr), 32'h17);
    finish_a(16'hABCD, 3);
    check("cur_vt_held", 32'(a_vt_sample), 32'h1234);
    @(posedge clk); #1;
    check("cur_wr_ptr", 32'(a_wr_ptr), 32'd1);

    // Wrap-around: five voltage samples into a 4-entry ring
    a_sel = 1'b0;
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      q_a.push_back('{ch: 1'b0, data: DW'(i)});
      wait_den(1'b0, n);
      finish_a(DW'(i), 3);
    end
    @(posedge clk); #1;
    check("wrap_wr_ptr", 32'(a_wr_ptr), 32'd1);
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      a_rd_addr = AW'(i);
      @(posedge clk); #1;
      check($sformatf("wrap_buf%0d", i), 32'(a_rd_data), 32'(wrap_exp[i]));
    end

    // Timeout: den with no drdy
    wait_den(1'b0, n);
    check("to_den_cycle", 32'(n + 4), 32'd8);
    repeat (4) @(posedge clk);
    #1;
    check("to_not_yet", 32'(a_to), 32'd0);
    @(posedge clk); #1;
    check("to_set", 32'(a_to), 32'd1);
    check("to_no_overrun", 32'(a_ovr), 32'd0);
    q_a.push_back('{ch: 1'b0, data: 16'h0777});
    wait_den(1'b0, n);
    check("to_next_den", 32'(n), 32'd3);
    check("to_next_daddr", 32'(a_daddr), 32'h16);
    finish_a(16'h0777, 2);
    check("to_sticky", 32'(a_to), 32'd1);
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    check("to_cleared", 32'(a_to), 32'd0);

    // Reset mid-WAIT followed by a late drdy
    a_sel = 1'b1;
    wait_den(1'b0, n);
    check("mid_daddr", 32'(a_daddr), 32'h17);
    @(posedge clk); #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    a_drdy = 1'b1;
    a_do = 16'hDEAD;
    check("mid_vt_sample", 32'(a_vt_sample), 32'd0);
    check("mid_outputs", 32'({a_den, a_vt_start, a_ct_start, a_ovr, a_to}), 32'd0);
    check("mid_daddr_rst", 32'(a_daddr), 32'h16);
    check("mid_wr_ptr", 32'(a_wr_ptr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    a_drdy = 1'b0;
    a_do = '0;
    a_sel = 1'b0;
    check("mid_late_drdy_ct", 32'(a_ct_sample), 32'd0);
    check("mid_late_drdy_vt", 32'(a_vt_sample), 32'd0);
    wait_den(1'b0, n);
    check("mid_den_cycle", 32'(n + 2), 32'd8);
    a_rst = 1'b1;

    // Overrun on instance B: drdy 10 cycles after den
    b_rst = 1'b0;
    q_b.push_back('{ch: 1'b0, data: 16'h0BEE});
    wait_den(1'b1, n);
    check("ovr_den_cycle", 32'(n), 32'd8);
    den_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      den_cnt += int'(b_den);
      if (k == 7) check("ovr_before_tick", 32'(b_ovr), 32'd0);
      if (k == 10) begin
        b_drdy = 1'b1;
        b_do = 16'h0BEE;
      end
    end
    @(posedge clk); #1;
    b_drdy = 1'b0;
    b_do = '0;
    check("ovr_dropped_den", 32'(den_cnt), 32'd0);
    check("ovr_set", 32'(b_ovr), 32'd1);
    b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;
    check("ovr_cleared", 32'(b_ovr), 32'd0);
    check("ovr_wr_ptr", 32'(b_wr_ptr), 32'd1);

    // Tick coinciding with DONE, clr_flags in the same cycle
    q_b.push_back('{ch: 1'b0, data: 16'h0CAF});
    wait_den(1'b1, n);
    check("ovr2_den", 32'(n), 32'd4);
    repeat (6) @(posedge clk);
    #1;
    b_drdy = 1'b1;
    b_do = 16'h0CAF;
    @(posedge clk); #1;
    b_drdy = 1'b0;
    b_do = '0;
    b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;
    check("ovr2_set_wins", 32'(b_ovr), 32'd1);
    check("ovr2_no_den", 32'(b_den), 32'd0);
    check("ovr2_wr_ptr", 32'(b_wr_ptr), 32'd2);
    b_rst = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    check("A_queue_empty", 32'(q_a.size()), 32'd0);
    check("B_queue_empty", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
